// File: rtl/guess_grader.sv
// Scores a 4-slot guess against the master code: exact (znarly) then partial (zood) matches.
// Latency: accept edge E0, results and gradeDone in the cycle after E20, idle again after E21.
// Backpressure: gradeStart is ignored while busy; bad requests pulse gradeErr. Option: GRADER_ROUNDS_EN.
module guess_grader #(
    parameter int NSLOT = 4,
    parameter int SW    = 3
) (
    input  logic          CLOCK_50,
    input  logic          reset_L,
    input  logic          resetMaster,
    input  logic [SW-1:0] master0,
    input  logic [SW-1:0] master1,
    input  logic [SW-1:0] master2,
    input  logic [SW-1:0] master3,
    input  logic          masterLoaded,
    input  logic [SW-1:0] guess0,
    input  logic [SW-1:0] guess1,
    input  logic [SW-1:0] guess2,
    input  logic [SW-1:0] guess3,
    input  logic          gradeStart,
    output logic          busy,
    output logic          gradeDone,
    output logic          gradeErr,
    output logic [2:0]    znarly,
    output logic [2:0]    zood,
`ifdef GRADER_ROUNDS_EN
    output logic [3:0]    round,
    output logic          gameOver,
`endif
    output logic          gameWon
);

    typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    g_q [NSLOT];
    logic [SW-1:0]    g_d [NSLOT];
    logic [SW-1:0]    m_q [NSLOT];
    logic [SW-1:0]    m_d [NSLOT];
    logic [NSLOT-1:0] exact_hit_q, exact_hit_d;
    logic [NSLOT-1:0] used_q, used_d;
    logic [1:0]       idx_q, idx_d, i_q, i_d, j_q, j_d;
    logic             found_q, found_d;
    logic [2:0]       zn_acc_q, zn_acc_d, zd_acc_q, zd_acc_d;
    logic [2:0]       znarly_q, znarly_d, zood_q, zood_d;
    logic             game_won_q, game_won_d;
    logic             grade_err_q, grade_err_d;
    logic             accept, hit;
`ifdef GRADER_ROUNDS_EN
    logic [3:0]       round_q, round_d;
    logic             game_over_q, game_over_d;
`endif

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        m_d         = m_q;
        exact_hit_d = exact_hit_q;
        used_d      = used_q;
        idx_d       = idx_q;
        i_d         = i_q;
        j_d         = j_q;
        found_d     = found_q;
        zn_acc_d    = zn_acc_q;
        zd_acc_d    = zd_acc_q;
        znarly_d    = znarly_q;
        zood_d      = zood_q;
        game_won_d  = game_won_q;
        grade_err_d = 1'b0;
        hit         = 1'b0;
`ifdef GRADER_ROUNDS_EN
        round_d     = round_q;
        game_over_d = game_over_q;
        accept = masterLoaded && !game_over_q && (guess0 != '0) && (guess1 != '0)
                 && (guess2 != '0) && (guess3 != '0);
`else
        accept = masterLoaded && (guess0 != '0) && (guess1 != '0)
                 && (guess2 != '0) && (guess3 != '0);
`endif

        case (state_q)
            IDLE: begin
                if (gradeStart) begin
                    if (accept) begin
                        g_d         = '{guess0, guess1, guess2, guess3};
                        m_d         = '{master0, master1, master2, master3};
                        exact_hit_d = '0;
                        used_d      = '0;
                        zn_acc_d    = '0;
                        zd_acc_d    = '0;
                        idx_d       = '0;
                        state_d     = EXACT;
                    end else begin
                        grade_err_d = 1'b1;
                    end
                end
            end
            EXACT: begin
                if (g_q[idx_q] == m_q[idx_q]) begin
                    exact_hit_d[idx_q] = 1'b1;
                    used_d[idx_q]      = 1'b1;
                    zn_acc_d           = zn_acc_q + 3'd1;
                end
                if (idx_q == 2'd3) begin
                    i_d     = '0;
                    j_d     = '0;
                    found_d = 1'b0;
                    state_d = PARTIAL;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            PARTIAL: begin
                // Each guess slot j claims at most one unused master slot i.
                hit = !exact_hit_q[j_q] && !found_q && !used_q[i_q] && (g_q[j_q] == m_q[i_q]);
                if (hit) begin
                    used_d[i_q] = 1'b1;
                    zd_acc_d    = zd_acc_q + 3'd1;
                end
                if (i_q == 2'd3) begin
                    i_d     = '0;
                    found_d = 1'b0;
                    if (j_q == 2'd3) begin
                        // Results are published on entry to DONE so they line up with gradeDone.
                        znarly_d = zn_acc_q;
                        zood_d   = zd_acc_d;
                        if (zn_acc_q == 3'd4) game_won_d = 1'b1;
`ifdef GRADER_ROUNDS_EN
                        round_d = (round_q == 4'd10) ? 4'd10 : round_q + 4'd1;
                        if (round_d == 4'd10 && !game_won_d) game_over_d = 1'b1;
`endif
                        state_d = DONE;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end else begin
                    i_d     = i_q + 2'd1;
                    found_d = found_q | hit;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (resetMaster) begin
            state_d     = IDLE;
            exact_hit_d = '0;
            used_d      = '0;
            idx_d       = '0;
            i_d         = '0;
            j_d         = '0;
            found_d     = 1'b0;
            zn_acc_d    = '0;
            zd_acc_d    = '0;
            znarly_d    = '0;
            zood_d      = '0;
            game_won_d  = 1'b0;
            grade_err_d = 1'b0;
`ifdef GRADER_ROUNDS_EN
            round_d     = '0;
            game_over_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            g_q         <= '{default: '0};
            m_q         <= '{default: '0};
            exact_hit_q <= '0;
            used_q      <= '0;
            idx_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            found_q     <= 1'b0;
            zn_acc_q    <= '0;
            zd_acc_q    <= '0;
            znarly_q    <= '0;
            zood_q      <= '0;
            game_won_q  <= 1'b0;
            grade_err_q <= 1'b0;
`ifdef GRADER_ROUNDS_EN
            round_q     <= '0;
            game_over_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            m_q         <= m_d;
            exact_hit_q <= exact_hit_d;
            used_q      <= used_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            j_q         <= j_d;
            found_q     <= found_d;
            zn_acc_q    <= zn_acc_d;
            zd_acc_q    <= zd_acc_d;
            znarly_q    <= znarly_d;
            zood_q      <= zood_d;
            game_won_q  <= game_won_d;
            grade_err_q <= grade_err_d;
`ifdef GRADER_ROUNDS_EN
            round_q     <= round_d;
            game_over_q <= game_over_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign gradeDone = (state_q == DONE);
    assign gradeErr  = grade_err_q;
    assign znarly    = znarly_q;
    assign zood      = zood_q;
    assign gameWon   = game_won_q;
`ifdef GRADER_ROUNDS_EN
    assign round     = round_q;
    assign gameOver  = game_over_q;
`endif

endmodule
